mccomp_regdump: RTL and testbench
=================================

# mccomp_regdump

Debug register-dump sequencer that sits directly downstream of the multi-cycle CPU's register-file debug port (`reg_sel`/`reg_data`). On a start pulse it sweeps `reg_sel` through every architectural register and latches each `reg_data` value. It then emits the values as a framed byte stream over a valid/ready interface toward a UART TX or a bench sink. This lets simulation and board bring-up dump the whole register file without probing hierarchy.

## Interface
- `NREGS`, 32: registers swept, indices 0..NREGS-1; legal range 1..32.
- `SETTLE`, 1: cycles `reg_sel` is held before `reg_data` is latched; must be ≥1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rstn` in 1: reset, asynchronous and active-low.
- `start` in 1: begin a dump; sampled only in IDLE.
- `reg_sel` out 5: register index driven to the CPU debug port.
- `reg_data` in 32: register value returned combinationally by the CPU for `reg_sel`.
- `byte_out` out 8: stream data.
- `byte_valid` out 1: `byte_out` is valid.
- `byte_ready` in 1: sink accepts; a transfer occurs on a rising edge where `byte_valid && byte_ready`.
- `busy` out 1: a dump is in progress.
- `done` out 1: one-cycle pulse when a dump completes.

## Operation
- Reset values: `reg_sel`=0, `byte_out`=0, `byte_valid`=0, `busy`=0, `done`=0, state=IDLE, byte index=0, shadow=0.
- FSM states: IDLE, SEL, SEND (plus CKSUM under the macro).
- **IDLE**:
  - With `start`=1 at an edge: go to SEL, set `busy`=1, `reg_sel`=0, settle count=0.
  - `start` is ignored while `busy`=1; no queuing.
- **SEL**:
  - The settle count increments each cycle.
  - On the edge where count==SETTLE-1: latch `reg_data` into a 32-bit shadow, go to SEND, set `byte_valid`=1, `byte_out`=`{3'b0,reg_sel}`, byte index=0.
- **SEND**: frames are 5 bytes per register, in this order:
  - index byte;
  - shadow[31:24];
  - shadow[23:16];
  - shadow[15:8];
  - shadow[7:0].
- SEND handshake:
  - `byte_out` holds stable while `byte_valid && !byte_ready`.
  - `byte_valid` never drops without a transfer.
  - Each transfer advances the byte index and loads the next byte on the same edge, so back-to-back transfers are possible.
- After the 5th transfer:
  - If `reg_sel`<NREGS-1: increment `reg_sel`, drop `byte_valid`, go to SEL.
  - Else: finish. This means IDLE, `busy`=0, `done`=1 for one cycle, `byte_valid`=0, `reg_sel` held at NREGS-1. Under the macro, go to CKSUM instead.
- Shadow isolation: changes on `reg_data` after the latch edge do not affect bytes already framed.
- Reset mid-dump:
  - `rstn` low asynchronously forces all reset values; no partial frame is resumed.
  - After release, a new `start` is required.
- `start` on the same edge `done` pulses is ignored, because the state is not yet IDLE.

## Timing
- `start` edge → `busy`=1 and `reg_sel`=0 visible after that edge.
- First `byte_valid` appears SETTLE cycles after `busy` rises.
- Per register, with `byte_ready` tied high: SETTLE + 5 cycles. `byte_valid` is low for SETTLE cycles between frames.
- Full dump, ready high: NREGS×(SETTLE+5) cycles from `busy` rising to the `done` pulse; default 192. Add 1 cycle under the macro.
- Backpressure:
  - Each cycle with `byte_valid`=1 and `byte_ready`=0 extends the dump by exactly one cycle.
  - `reg_sel` is stable throughout SEND.
- `done` and `busy` falling occur on the same edge.

## Configuration
- Macro: `REGDUMP_CKSUM_EN`.
- Defined:
  - After the final register frame, CKSUM emits one extra byte equal to the XOR of every byte already emitted in this dump.
  - It uses the same handshake rules as SEND.
  - `done` pulses on that byte's transfer.
  - The accumulator clears on `start` and on reset.
- Undefined: no CKSUM state, no accumulator; the dump ends after the last register frame.

## Test plan
- **Stub CPU, default params, `byte_ready`=1.** Stub returns `reg_data`=32'hDEAD0000 | `reg_sel`. Pulse `start`.
  - Frame 7 is 07,DE,AD,00,07.
  - 160 bytes total.
  - `done` asserts exactly 192 cycles after `busy` rises.
- **Backpressure.** `byte_ready` toggles 1,0,1,0 during SEND.
  - `byte_out` holds across every ready-low cycle.
  - No byte is duplicated or dropped.
  - `done` is delayed by exactly the count of stalled valid cycles.
- **SETTLE=3, NREGS=2.**
  - `reg_sel` is held 3 cycles before each frame.
  - `done` asserts 16 cycles after `busy` rises.
  - `reg_data` changed after the latch edge does not corrupt the frame.
- **`start` while busy, and `rstn` low mid-frame.**
  - A `start` pulse mid-dump has no effect.
  - Asserting `rstn` low during byte 3 of frame 5 gives all reset values immediately.
  - A subsequent `start` restarts from reg 0.
- **`REGDUMP_CKSUM_EN`, NREGS=3, stub as above.**
  - 16th byte = 8'h73.
  - `done` follows its transfer.
  - Without the macro, 15 bytes are sent and the checksum byte is absent.

Source files
------------

// File: rtl/mccomp_regdump.sv
// Register-dump sequencer: sweeps the CPU debug port and streams 5-byte frames (index, data MSB..LSB).
// Optional feature macro REGDUMP_CKSUM_EN appends one XOR checksum byte after the last frame.
module mccomp_regdump #(
  parameter int NREGS  = 32,
  parameter int SETTLE = 1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  output logic [4:0]  reg_sel_o,
  input  logic [31:0] reg_data_i,
  output logic [7:0]  byte_out_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [4:0] LAST_SEL = 5'(NREGS - 1);

`ifdef REGDUMP_CKSUM_EN
  typedef enum logic [1:0] {IDLE, SEL, SEND, CKSUM} state_e;
`else
  typedef enum logic [1:0] {IDLE, SEL, SEND} state_e;
`endif

  state_e        state_q, state_d;
  logic [4:0]    reg_sel_q, reg_sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [7:0]    byte_out_q, byte_out_d;
  logic          byte_valid_q, byte_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef REGDUMP_CKSUM_EN
  logic [7:0]    acc_q, acc_d;
`endif

  logic       xfer;
  logic [7:0] next_byte;

  assign xfer = byte_valid_q & byte_ready_i;

  // Byte that follows the one currently presented at byte_idx_q.
  always_comb begin
    next_byte = shadow_q[7:0];
    case (byte_idx_q)
      3'd0:    next_byte = shadow_q[31:24];
      3'd1:    next_byte = shadow_q[23:16];
      3'd2:    next_byte = shadow_q[15:8];
      default: next_byte = shadow_q[7:0];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    reg_sel_d    = reg_sel_q;
    cnt_d        = cnt_q;
    byte_idx_d   = byte_idx_q;
    shadow_d     = shadow_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = byte_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
`ifdef REGDUMP_CKSUM_EN
    acc_d        = acc_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = SEL;
          busy_d    = 1'b1;
          reg_sel_d = 5'd0;
          cnt_d     = '0;
`ifdef REGDUMP_CKSUM_EN
          acc_d     = 8'd0;
`endif
        end
      end

      SEL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          shadow_d     = reg_data_i;
          state_d      = SEND;
          byte_valid_d = 1'b1;
          byte_out_d   = {3'b000, reg_sel_q};
          byte_idx_d   = 3'd0;
        end
      end

      SEND: begin
        if (xfer) begin
`ifdef REGDUMP_CKSUM_EN
          acc_d = acc_q ^ byte_out_q;
`endif
          if (byte_idx_q == 3'd4) begin
            if (reg_sel_q < LAST_SEL) begin
              reg_sel_d    = reg_sel_q + 5'd1;
              byte_valid_d = 1'b0;
              cnt_d        = '0;
              state_d      = SEL;
            end else begin
`ifdef REGDUMP_CKSUM_EN
              state_d    = CKSUM;
              byte_out_d = acc_q ^ byte_out_q;
`else
              state_d      = IDLE;
              busy_d       = 1'b0;
              done_d       = 1'b1;
              byte_valid_d = 1'b0;
`endif
            end
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            byte_out_d = next_byte;
          end
        end
      end

`ifdef REGDUMP_CKSUM_EN
      CKSUM: begin
        if (xfer) begin
          state_d      = IDLE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          byte_valid_d = 1'b0;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      reg_sel_q    <= 5'd0;
      cnt_q        <= '0;
      byte_idx_q   <= 3'd0;
      shadow_q     <= 32'd0;
      byte_out_q   <= 8'd0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef REGDUMP_CKSUM_EN
      acc_q        <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      reg_sel_q    <= reg_sel_d;
      cnt_q        <= cnt_d;
      byte_idx_q   <= byte_idx_d;
      shadow_q     <= shadow_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef REGDUMP_CKSUM_EN
      acc_q        <= acc_d;
`endif
    end
  end

  assign reg_sel_o    = reg_sel_q;
  assign byte_out_o   = byte_out_q;
  assign byte_valid_o = byte_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_mccomp_regdump.sv
// Directed bench for mccomp_regdump: three instances (default, SETTLE=3/NREGS=2, NREGS=3) share one clock.
module tb_mccomp_regdump;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start [3];
  logic        ready [3];
  logic [4:0]  sel   [3];
  logic [31:0] data  [3];
  logic [7:0]  bout  [3];
  logic        valid [3];
  logic        busy  [3];
  logic        done  [3];
  logic [7:0]  got_q [$];
  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  // Stub CPU; data is scrambled whenever a frame is being sent, so a late latch shows up.
  for (genvar k = 0; k < 3; k++) begin : g_stub
    assign data[k] = (32'hDEAD0000 | {27'd0, sel[k]}) ^ (valid[k] ? 32'hFFFF_FFFF : 32'd0);
  end

  mccomp_regdump #(.NREGS(32), .SETTLE(1)) u_def (
    .clk_i(clk), .rstn_i(rstn), .start_i(start[0]), .reg_sel_o(sel[0]), .reg_data_i(data[0]),
    .byte_out_o(bout[0]), .byte_valid_o(valid[0]), .byte_ready_i(ready[0]),
    .busy_o(busy[0]), .done_o(done[0]));

  mccomp_regdump #(.NREGS(2), .SETTLE(3)) u_s3 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start[1]), .reg_sel_o(sel[1]), .reg_data_i(data[1]),
    .byte_out_o(bout[1]), .byte_valid_o(valid[1]), .byte_ready_i(ready[1]),
    .busy_o(busy[1]), .done_o(done[1]));

  mccomp_regdump #(.NREGS(3), .SETTLE(1)) u_n3 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start[2]), .reg_sel_o(sel[2]), .reg_data_i(data[2]),
    .byte_out_o(bout[2]), .byte_valid_o(valid[2]), .byte_ready_i(ready[2]),
    .busy_o(busy[2]), .done_o(done[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Mismatches of the first n captured bytes against the stub frame pattern.
  function automatic int frame_errs(input int n);
    int e = 0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] r, x;
      r = 8'(i / 5);
      case (i % 5)
        0, 4:    x = r;
        1:       x = 8'hDE;
        2:       x = 8'hAD;
        default: x = 8'h00;
      endcase
      if (i >= got_q.size() || got_q[i] !== x) e++;
    end
    return e;
  endfunction

  task automatic run_dump(input int k, input bit toggle, input int maxc,
                          output int len, output int stalls, output int holderr, output int gaps);
    int cb, cd;
    logic [7:0] pv;
    bit pstall;
    got_q.delete();
    cb = -1; cd = -1; stalls = 0; holderr = 0; gaps = 0; pstall = 0; pv = 8'd0;
    ready[k] = 1'b1;
    @(negedge clk); start[k] = 1'b1;
    @(negedge clk); start[k] = 1'b0;
    for (int c = 0; c < maxc && cd < 0; c++) begin
      ready[k] = toggle ? (c % 2 == 0) : 1'b1;
      #1;
      if (busy[k] && cb < 0) cb = c;
      if (done[k]) cd = c;
      if (pstall && (bout[k] !== pv || !valid[k])) holderr++;
      if (valid[k] && ready[k]) got_q.push_back(bout[k]);
      if (valid[k] && !ready[k]) stalls++;
      if (busy[k] && !valid[k]) gaps++;
      pstall = valid[k] && !ready[k];
      pv = bout[k];
      @(negedge clk);
    end
    ready[k] = 1'b1;
    len = (cb >= 0 && cd >= 0) ? cd - cb : -1;
    #1;
    chk("done_one_cycle", done[k], 1'b0);
  endtask

  initial begin
    int len, stl, hold, gaps;
    logic [7:0] f7 [5];
    f7[0] = 8'h07; f7[1] = 8'hDE; f7[2] = 8'hAD; f7[3] = 8'h00; f7[4] = 8'h07;

    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      ready[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sel", sel[0], 5'd0);
    chk("rst_bout", bout[0], 8'd0);
    chk("rst_valid", valid[0], 1'b0);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_done", done[0], 1'b0);
    @(negedge clk); rstn = 1'b1;

    // Default parameters, ready held high.
    run_dump(0, 1'b0, 400, len, stl, hold, gaps);
    chk("t1_len", len, 192);
    chk("t1_nbytes", got_q.size(), 160);
    chk("t1_model", frame_errs(160), 0);
    for (int j = 0; j < 5; j++) chk($sformatf("t1_frame7_b%0d", j), got_q[35 + j], f7[j]);
    chk("t1_stalls", stl, 0);
    chk("t1_gaps", gaps, 32);

    // Alternating ready: 5 stalls on the first frame, 4 on each of the other 31.
    run_dump(0, 1'b1, 800, len, stl, hold, gaps);
    chk("t2_stalls", stl, 129);
    chk("t2_len", len, 321);
    chk("t2_len_vs_stalls", len, 192 + stl);
    chk("t2_hold", hold, 0);
    chk("t2_nbytes", got_q.size(), 160);
    chk("t2_model", frame_errs(160), 0);

    // SETTLE=3, NREGS=2.
    run_dump(1, 1'b0, 100, len, stl, hold, gaps);
    chk("t3_len", len, 16);
    chk("t3_settle_gaps", gaps, 6);
    chk("t3_nbytes", got_q.size(), 10);
    chk("t3_model", frame_errs(10), 0);

    // Start while busy, then reset during the third byte of frame 5.
    got_q.delete();
    ready[0] = 1'b1;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    for (int c = 0; c < 400 && got_q.size() < 27; c++) begin
      start[0] = (c == 10);
      #1;
      if (valid[0] && ready[0]) got_q.push_back(bout[0]);
      @(negedge clk);
    end
    start[0] = 1'b0;
    #1;
    chk("t4_nbytes", got_q.size(), 27);
    chk("t4_model", frame_errs(27), 0);
    chk("t4_sel", sel[0], 5'd5);
    chk("t4_bout", bout[0], 8'hAD);
    chk("t4_valid", valid[0], 1'b1);
    rstn = 1'b0;
    #1;
    chk("t4_rst_sel", sel[0], 5'd0);
    chk("t4_rst_bout", bout[0], 8'd0);
    chk("t4_rst_valid", valid[0], 1'b0);
    chk("t4_rst_busy", busy[0], 1'b0);
    chk("t4_rst_done", done[0], 1'b0);
    @(negedge clk); rstn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t4_idle_busy", busy[0], 1'b0);
    chk("t4_idle_valid", valid[0], 1'b0);
    run_dump(0, 1'b0, 400, len, stl, hold, gaps);
    chk("t4_restart_len", len, 192);
    chk("t4_restart_nbytes", got_q.size(), 160);
    chk("t4_restart_model", frame_errs(160), 0);

    // NREGS=3: checksum byte only when the feature is built in.
    run_dump(2, 1'b0, 100, len, stl, hold, gaps);
    chk("t5_model", frame_errs(15), 0);
`ifdef REGDUMP_CKSUM_EN
    chk("t5_len", len, 19);
    chk("t5_nbytes", got_q.size(), 16);
    chk("t5_cksum", got_q[15], 8'h73);
`else
    chk("t5_len", len, 18);
    chk("t5_nbytes", got_q.size(), 15);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
